// File: rtl/core_boot_sequencer.sv
// Core boot sequencer: on a start edge, latch the boot address, hold the core in reset,
// release it, enable fetch, and track completion, watchdog expiry and run length.
module core_boot_sequencer #(
  parameter int                    ADDR_WIDTH        = 64,
  parameter int                    RST_HOLD_CYCLES   = 16,
  parameter int                    TIMEOUT_CYCLES    = 0,
  parameter int                    CNT_WIDTH         = 32,
  parameter logic [ADDR_WIDTH-1:0] DEFAULT_BOOT_ADDR = '0
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] boot_addr_i,
  input  logic                  core_done_i,
  output logic                  core_rst_o,
  output logic                  core_fetch_en_o,
  output logic [ADDR_WIDTH-1:0] core_boot_addr_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  timeout_o,
  output logic [CNT_WIDTH-1:0]  cycle_count_o
);

  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam bit                   WDOG_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    IDLE,
    RESET_HOLD,
    RUN,
    DONE,
    TIMEOUT
  } state_t;

  state_t            state;
  logic              start_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic              launch;

  // start_q clears on reset, so a start already high right after reset is a fresh edge
  assign launch = start_i & ~start_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state            <= IDLE;
      start_q          <= 1'b0;
      hold_cnt         <= '0;
      core_rst_o       <= 1'b1;
      core_fetch_en_o  <= 1'b0;
      core_boot_addr_o <= DEFAULT_BOOT_ADDR;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      timeout_o        <= 1'b0;
      cycle_count_o    <= '0;
    end else begin
      start_q <= start_i;
      case (state)
        IDLE, DONE, TIMEOUT: begin
          if (launch) begin
            state            <= RESET_HOLD;
            core_boot_addr_o <= boot_addr_i;
            hold_cnt         <= '0;
            cycle_count_o    <= '0;
            done_o           <= 1'b0;
            timeout_o        <= 1'b0;
            busy_o           <= 1'b1;
            core_rst_o       <= 1'b1;
            core_fetch_en_o  <= 1'b0;
          end
        end
        RESET_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state      <= RUN;
            core_rst_o <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          if (cycle_count_o != '1) begin
            cycle_count_o <= cycle_count_o + 1'b1;
          end
          // Completion takes priority over a watchdog expiry in the same cycle
          if (core_done_i) begin
            state           <= DONE;
            done_o          <= 1'b1;
            busy_o          <= 1'b0;
            core_rst_o      <= 1'b1;
            core_fetch_en_o <= 1'b0;
          end else if (WDOG_EN && cycle_count_o == TO_LAST) begin
            state           <= TIMEOUT;
            timeout_o       <= 1'b1;
            busy_o          <= 1'b0;
            core_rst_o      <= 1'b1;
            core_fetch_en_o <= 1'b0;
          end else begin
            core_fetch_en_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
